game_score_timer: RTL and testbench

- Produces the `start`, `count[15:0]` and `score[15:0]` values consumed by the seven-segment multiplexer stage.
- Runs a pre-game BCD countdown on a divided one-second tick. When the countdown reaches zero it enters play and raises `start`.
- During play it accumulates a 4-digit BCD score from `hit` pulses.
- All outputs are registered and hold stable between updates, so the display stage can sample them on any clock.

---
 rtl/game_pkg.sv | 16 +
 rtl/bcd4_step.sv | 45 ++++
 rtl/game_score_timer.sv | 123 ++++++++++++
 tb/tb_game_score_timer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game score/timer block.
//   state_t  : top-level game phase
//   BCD_MAX  : largest 4-digit packed BCD value
//   BCD_ZERO : packed BCD zero
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        PLAY      = 2'd2
    } state_t;

    localparam logic [15:0] BCD_MAX  = 16'h9999;
    localparam logic [15:0] BCD_ZERO = 16'h0000;

endpackage

// File: rtl/bcd4_step.sv
// Combinational 4-digit packed BCD +/-1 unit.
//   value    : packed BCD operand (digit 3 in [15:12])
//   dir      : 0 = increment, 1 = decrement
//   result   : value +/- 1, carry/borrow rippled digit by digit (wraps at the ends)
//   at_limit : operand is already at the end of travel (9999 on inc, 0000 on dec)
module bcd4_step
    import game_pkg::*;
(
    input  logic [15:0] value,
    input  logic        dir,
    output logic [15:0] result,
    output logic        at_limit
);

    logic [3:0] digit;
    logic       ripple;

    always_comb begin
        result = value;
        digit  = 4'd0;
        ripple = 1'b1;
        // Only digits reached by the ripple change; a digit at 9 (inc) or
        // 0 (dec) rolls over and passes the ripple on to the next digit.
        for (int i = 0; i < 4; i++) begin
            digit = value[i*4 +: 4];
            if (ripple) begin
                if (!dir) begin
                    if (digit == 4'd9) result[i*4 +: 4] = 4'd0;
                    else begin
                        result[i*4 +: 4] = digit + 4'd1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) result[i*4 +: 4] = 4'd9;
                    else begin
                        result[i*4 +: 4] = digit - 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
        end
        at_limit = dir ? (value == BCD_ZERO) : (value == BCD_MAX);
    end

endmodule

// File: rtl/game_score_timer.sv
// Pre-game BCD countdown followed by a BCD hit score, feeding the display mux.
//   clock, reset : system clock, asynchronous active-low reset
//   arm          : start/restart the countdown (from PLAY also zeroes score)
//   hit          : score event, rising-edge detected
//   clear_score  : zero the score in any state (beats a simultaneous hit)
//   start        : 1 while in PLAY
//   count        : packed BCD countdown value
//   score        : packed BCD score, saturates at 9999
//   tick         : one-cycle strobe on the last prescaler count
module game_score_timer
    import game_pkg::*;
#(
    parameter int          TICK_DIV   = 100000000,
    parameter logic [15:0] COUNT_INIT = 16'h0005
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arm,
    input  logic        hit,
    input  logic        clear_score,
    output logic        start,
    output logic [15:0] count,
    output logic [15:0] score,
    output logic        tick
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    // A zero preset has nothing to count down, so arm goes straight to PLAY.
    localparam state_t        ARM_STATE  = (COUNT_INIT == BCD_ZERO) ? PLAY : COUNTDOWN;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [15:0]   count_nxt, score_nxt;
    logic          start_nxt, tick_nxt;
    logic          hit_q, hit_rise;
    logic [15:0]   score_inc, count_dec;
    logic          score_full, count_empty;

    assign hit_rise = hit & ~hit_q;

    bcd4_step u_score_inc (
        .value    (score),
        .dir      (1'b0),
        .result   (score_inc),
        .at_limit (score_full)
    );

    bcd4_step u_count_dec (
        .value    (count),
        .dir      (1'b1),
        .result   (count_dec),
        .at_limit (count_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            presc <= '0;
            count <= COUNT_INIT;
            score <= BCD_ZERO;
            start <= 1'b0;
            tick  <= 1'b0;
            hit_q <= 1'b0;
        end else begin
            state <= state_nxt;
            presc <= presc_nxt;
            count <= count_nxt;
            score <= score_nxt;
            start <= start_nxt;
            tick  <= tick_nxt;
            hit_q <= hit;
        end
    end

    always_comb begin
        state_nxt = state;
        presc_nxt = '0;
        count_nxt = count;
        score_nxt = score;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_nxt = ARM_STATE;
                    count_nxt = COUNT_INIT;
                end
            end
            COUNTDOWN: begin
                if (arm) begin
                    count_nxt = COUNT_INIT;
                end else begin
                    presc_nxt = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
                    // tick is the registered decode of presc == PRESC_LAST,
                    // so it marks the wrap cycle itself.
                    if (tick && !count_empty) begin
                        count_nxt = count_dec;
                        if (count_dec == BCD_ZERO) begin
                            state_nxt = PLAY;
                            presc_nxt = '0;
                        end
                    end
                end
            end
            PLAY: begin
                if (arm) begin
                    state_nxt = ARM_STATE;
                    count_nxt = COUNT_INIT;
                    score_nxt = BCD_ZERO;
                end else if (hit_rise && !score_full) begin
                    score_nxt = score_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = COUNT_INIT;
            end
        endcase
        if (clear_score) score_nxt = BCD_ZERO;
        start_nxt = (state_nxt == PLAY);
        tick_nxt  = (state_nxt == COUNTDOWN) && (presc_nxt == PRESC_LAST);
    end

endmodule

// File: tb/tb_game_score_timer.sv
module tb_game_score_timer;

    localparam int TICK_DIV = 4;
    localparam int INIT_DEC = 12;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        arm = 1'b0, arm_b = 1'b0, hit = 1'b0, clear_score = 1'b0;
    logic        start, tick, start_b, tick_b;
    logic [15:0] count, score, count_b, score_b;

    int checks = 0;
    int failures = 0;

    // reference model: game phase, decimal count/score, cycles into current tick
    int   m_mode;   // 0 idle, 1 countdown, 2 play
    int   m_cnt, m_score, m_cyc;
    logic m_hitq, m_tick;

    game_score_timer #(.TICK_DIV(TICK_DIV), .COUNT_INIT(16'h0012)) dut (
        .clock(clock), .reset(reset), .arm(arm), .hit(hit), .clear_score(clear_score),
        .start(start), .count(count), .score(score), .tick(tick)
    );

    game_score_timer #(.TICK_DIV(TICK_DIV), .COUNT_INIT(16'h0000)) dut_zero (
        .clock(clock), .reset(reset), .arm(arm_b), .hit(hit), .clear_score(clear_score),
        .start(start_b), .count(count_b), .score(score_b), .tick(tick_b)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = INIT_DEC; m_score = 0; m_cyc = 0; m_hitq = 1'b0; m_tick = 1'b0;
    endtask

    // drive one cycle of inputs, advance the model across the edge, settle
    task automatic step(input logic a, input logic h, input logic c);
        logic rise;
        @(negedge clock);
        arm = a; hit = h; clear_score = c;
        @(posedge clock);
        rise = h && !m_hitq;
        m_hitq = h;
        case (m_mode)
            0: if (a) begin m_mode = 1; m_cnt = INIT_DEC; m_cyc = 0; end
            1: if (a) begin m_cnt = INIT_DEC; m_cyc = 0; end
               else begin
                   m_cyc++;
                   if (m_cyc == TICK_DIV) begin
                       m_cyc = 0; m_cnt--;
                       if (m_cnt == 0) m_mode = 2;
                   end
               end
            default: if (a) begin m_mode = 1; m_cnt = INIT_DEC; m_cyc = 0; m_score = 0; end
                     else if (rise && m_score < 9999) m_score++;
        endcase
        if (c) m_score = 0;
        m_tick = (m_mode == 1) && (m_cyc == TICK_DIV - 1);
        #1;
    endtask

    task automatic test_reset();
        int n;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        checks++; if (count !== 16'h0012) begin failures++; $display("FAIL reset_count got=%h exp=0012", count); end
        checks++; if (score !== 16'h0000) begin failures++; $display("FAIL reset_score got=%h exp=0000", score); end
        checks++; if (start !== 1'b0 || tick !== 1'b0) begin failures++; $display("FAIL reset_flags start=%b tick=%b exp=0/0", start, tick); end
        @(negedge clock); reset = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        n = 0;
        while (m_cnt != 7 && n < 100) begin step(1'b0, 1'b0, 1'b0); n++; end
        checks++; if (count !== 16'h0007) begin failures++; $display("FAIL pre_reset_count got=%h exp=0007", count); end
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++; if (count !== 16'h0012 || score !== 16'h0000 || start !== 1'b0 || tick !== 1'b0) begin
            failures++; $display("FAIL async_reset count=%h score=%h start=%b tick=%b exp 0012/0000/0/0", count, score, start, tick);
        end
        @(negedge clock); reset = 1'b1;
        repeat (8) begin
            step(1'b0, 1'b0, 1'b0);
            checks++; if (tick !== 1'b0 || start !== 1'b0 || count !== 16'h0012) begin
                failures++; $display("FAIL idle_after_reset tick=%b start=%b count=%h exp 0/0/0012", tick, start, count);
            end
        end
    endtask

    task automatic test_countdown();
        int n;
        step(1'b1, 1'b0, 1'b0);
        n = 0;
        while (start !== 1'b1 && n < 200) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
            checks++; if (count !== to_bcd(m_cnt) || tick !== m_tick || start !== (m_mode == 2)) begin
                failures++; $display("FAIL countdown_cycle%0d count=%h tick=%b start=%b exp %h/%b/%b", n, count, tick, start, to_bcd(m_cnt), m_tick, m_mode == 2);
            end
        end
        checks++; if (n != 48) begin failures++; $display("FAIL start_latency got=%0d exp=48", n); end
        checks++; if (count !== 16'h0000) begin failures++; $display("FAIL play_count got=%h exp=0000", count); end
    endtask

    task automatic test_hit();
        repeat (10) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++; if (score !== 16'h0001) begin failures++; $display("FAIL held_hit got=%h exp=0001", score); end
        repeat (3) begin step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); end
        checks++; if (score !== 16'h0004) begin failures++; $display("FAIL three_pulses got=%h exp=0004", score); end
        while (m_score < 9999) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            checks++; if (score !== to_bcd(m_score)) begin
                failures++; $display("FAIL score_inc got=%h exp=%h", score, to_bcd(m_score));
            end
            if (m_score == 100) begin
                checks++; if (score !== 16'h0100) begin failures++; $display("FAIL carry_0100 got=%h exp=0100", score); end
            end
            if (m_score == 1000) begin
                checks++; if (score !== 16'h1000) begin failures++; $display("FAIL carry_1000 got=%h exp=1000", score); end
            end
        end
        repeat (3) begin step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); end
        checks++; if (score !== 16'h9999) begin failures++; $display("FAIL saturate got=%h exp=9999", score); end
    endtask

    task automatic test_arm_hit();
        step(1'b1, 1'b1, 1'b0);
        checks++; if (score !== 16'h0000 || start !== 1'b0 || count !== 16'h0012) begin
            failures++; $display("FAIL arm_beats_hit score=%h start=%b count=%h exp 0000/0/0012", score, start, count);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_clear();
        int n;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++; if (score !== 16'h0000) begin failures++; $display("FAIL countdown_hit got=%h exp=0000", score); end
        n = 0;
        while (start !== 1'b1 && n < 200) begin step(1'b0, 1'b0, 1'b0); n++; end
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL reach_play start=%b exp=1", start); end
        repeat (42) begin step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); end
        checks++; if (score !== 16'h0042) begin failures++; $display("FAIL score_42 got=%h exp=0042", score); end
        step(1'b0, 1'b1, 1'b1);
        checks++; if (score !== 16'h0000) begin failures++; $display("FAIL clear_beats_hit got=%h exp=0000", score); end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_zero_init();
        @(negedge clock); arm_b = 1'b1;
        @(posedge clock); #1;
        checks++; if (start_b !== 1'b1 || count_b !== 16'h0000) begin
            failures++; $display("FAIL zero_init_arm start=%b count=%h exp 1/0000", start_b, count_b);
        end
        @(negedge clock); arm_b = 1'b0;
        repeat (20) begin
            @(posedge clock); #1;
            checks++; if (tick_b !== 1'b0 || start_b !== 1'b1) begin
                failures++; $display("FAIL zero_init_hold tick=%b start=%b exp 0/1", tick_b, start_b);
            end
        end
    endtask

    task automatic test_random();
        logic a, h, c;
        repeat (800) begin
            a = ($urandom_range(0, 39) == 0);
            h = $urandom_range(0, 1) == 1;
            c = ($urandom_range(0, 49) == 0);
            step(a, h, c);
            checks++; if (count !== to_bcd(m_cnt) || score !== to_bcd(m_score) || start !== (m_mode == 2) || tick !== m_tick) begin
                failures++; $display("FAIL random count=%h score=%h start=%b tick=%b exp %h/%h/%b/%b",
                                     count, score, start, tick, to_bcd(m_cnt), to_bcd(m_score), m_mode == 2, m_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_hit();
        test_arm_hit();
        test_clear();
        test_zero_init();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
